// File: rtl/datapath_sequencer.sv
// datapath_sequencer: instruction-fed control sequencer for the 4-register ALU
// datapath. Each accepted instruction gets one write cycle (wr=1) followed by
// one settle cycle; a HALT opcode parks the sequencer until resume.
module datapath_sequencer #(
    parameter int              ADDR_W  = 2,
    parameter int              OP_W    = 3,
    parameter int              CNT_W   = 8,
    parameter logic [OP_W-1:0] HALT_OP = 3'b111
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [OP_W+3*ADDR_W-1:0]   in_instr,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       resume,
    output logic [ADDR_W-1:0]          addr1,
    output logic [ADDR_W-1:0]          addr2,
    output logic [ADDR_W-1:0]          addr3,
    output logic [OP_W-1:0]            ALUControl,
    output logic                       wr,
    output logic                       halted,
    output logic [CNT_W-1:0]           retired
);

    localparam int IW = OP_W + 3*ADDR_W;

    typedef enum logic [1:0] {IDLE, WRITE, SETTLE, HALTED} state_t;

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_addr1, r_addr2, r_addr3;
    logic [OP_W-1:0]     r_alu;
    logic                r_wr;
    logic                r_halted;
    logic [CNT_W-1:0]    r_retired;

    logic                w_hs;
    logic                w_is_halt;
    logic [OP_W-1:0]     w_op;
    logic [ADDR_W-1:0]   w_a1, w_a2, w_a3;

    // Field split of {op, addr3, addr1, addr2}
    assign w_op      = in_instr[IW-1 -: OP_W];
    assign w_a3      = in_instr[3*ADDR_W-1 -: ADDR_W];
    assign w_a1      = in_instr[2*ADDR_W-1 -: ADDR_W];
    assign w_a2      = in_instr[ADDR_W-1:0];
    assign w_is_halt = (w_op == HALT_OP);

    // Ready is the only combinational output; it drops immediately under reset
    assign in_ready = ((r_state == IDLE) || (r_state == SETTLE)) && rst;
    assign w_hs     = in_valid && in_ready;

    // Next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, SETTLE: begin
                if (w_hs) w_next = w_is_halt ? HALTED : WRITE;
                else      w_next = IDLE;
            end
            WRITE:   w_next = SETTLE;
            HALTED:  if (resume) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // State, registered outputs and retired counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_addr1   <= '0;
            r_addr2   <= '0;
            r_addr3   <= '0;
            r_alu     <= '0;
            r_wr      <= 1'b0;
            r_halted  <= 1'b0;
            r_retired <= '0;
        end else begin
            r_state  <= w_next;
            r_wr     <= (w_next == WRITE);
            r_halted <= (w_next == HALTED);
            // Fields only load on a non-HALT handshake, which never happens in WRITE,
            // so addresses stay stable for the whole wr pulse.
            if (w_hs && !w_is_halt) begin
                r_addr1 <= w_a1;
                r_addr2 <= w_a2;
                r_addr3 <= w_a3;
                r_alu   <= w_op;
            end
            if (r_state == WRITE)
                r_retired <= r_retired + CNT_W'(1);
        end
    end

    assign addr1      = r_addr1;
    assign addr2      = r_addr2;
    assign addr3      = r_addr3;
    assign ALUControl = r_alu;
    assign wr         = r_wr;
    assign halted     = r_halted;
    assign retired    = r_retired;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Bench for datapath_sequencer: directed steps plus random traffic, checked
// against a transaction-level model (busy/halt flags, issue fields, counter).
// A second instance with a 2-bit counter shares the stimulus to cover wrap.
module tb_datapath_sequencer;

    logic       clk, rst, in_valid, resume;
    logic [8:0] in_instr;

    logic       in_ready, wr, halted;
    logic [1:0] addr1, addr2, addr3;
    logic [2:0] alu;
    logic [7:0] retired;

    logic       in_ready_w, wr_w, halted_w;
    logic [1:0] addr1_w, addr2_w, addr3_w;
    logic [2:0] alu_w;
    logic [1:0] retired_w;

    datapath_sequencer #(.ADDR_W(2), .OP_W(3), .CNT_W(8), .HALT_OP(3'b111)) dut (
        .clk(clk), .rst(rst), .in_instr(in_instr), .in_valid(in_valid), .in_ready(in_ready),
        .resume(resume), .addr1(addr1), .addr2(addr2), .addr3(addr3), .ALUControl(alu),
        .wr(wr), .halted(halted), .retired(retired));

    datapath_sequencer #(.ADDR_W(2), .OP_W(3), .CNT_W(2), .HALT_OP(3'b111)) dut_w (
        .clk(clk), .rst(rst), .in_instr(in_instr), .in_valid(in_valid), .in_ready(in_ready_w),
        .resume(resume), .addr1(addr1_w), .addr2(addr2_w), .addr3(addr3_w), .ALUControl(alu_w),
        .wr(wr_w), .halted(halted_w), .retired(retired_w));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state
    logic       m_busy = 1'b0, m_halt = 1'b0, m_wr = 1'b0;
    logic [1:0] m_a1 = '0, m_a2 = '0, m_a3 = '0;
    logic [2:0] m_alu = '0;
    int         m_ret = 0;
    logic       prev_wr = 1'b0;
    logic [7:0] rf [4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] mk(input logic [2:0] op, input logic [1:0] a3,
                                      input logic [1:0] a1, input logic [1:0] a2);
        return {op, a3, a1, a2};
    endfunction

    // One clock: drive, check ready, advance datapath + model, check outputs
    task automatic step(input logic r, input logic v, input logic res,
                        input logic [8:0] ins, output logic acc);
        logic m_ready;
        rst = r; in_valid = v; resume = res; in_instr = ins;
        #1;
        m_ready = r && !m_halt && !m_busy;
        chk("in_ready", 32'(in_ready), 32'(m_ready));
        // Register file stand-in captures at this edge when wr is high
        if (wr) begin
            case (alu)
                3'b000:  rf[addr3] = rf[addr1] + rf[addr2];
                3'b001:  rf[addr3] = rf[addr1] - rf[addr2];
                3'b010:  rf[addr3] = rf[addr1] & rf[addr2];
                default: rf[addr3] = rf[addr3];
            endcase
        end
        prev_wr = wr;
        acc = m_ready && v;
        if (!r) begin
            m_busy = 0; m_halt = 0; m_wr = 0;
            m_a1 = 0; m_a2 = 0; m_a3 = 0; m_alu = 0; m_ret = 0;
        end else begin
            if (m_busy) m_ret++;
            m_wr = 0;
            if (m_halt) begin
                if (res) m_halt = 0;
            end else if (acc) begin
                if (ins[8:6] == 3'b111) m_halt = 1;
                else begin
                    m_alu = ins[8:6]; m_a3 = ins[5:4]; m_a1 = ins[3:2]; m_a2 = ins[1:0];
                    m_wr = 1;
                end
            end
            m_busy = m_wr;
        end
        @(posedge clk);
        #1;
        chk("wr", 32'(wr), 32'(m_wr));
        chk("wr_w", 32'(wr_w), 32'(m_wr));
        chk("wr_b2b", 32'(prev_wr && wr), 32'(0));
        chk("halted", 32'(halted), 32'(m_halt));
        chk("addr1", 32'(addr1), 32'(m_a1));
        chk("addr2", 32'(addr2), 32'(m_a2));
        chk("addr3", 32'(addr3), 32'(m_a3));
        chk("alu", 32'(alu), 32'(m_alu));
        chk("retired", 32'(retired), 32'(m_ret % 256));
        chk("retired_w", 32'(retired_w), 32'(m_ret % 4));
    endtask

    initial begin
        logic       acc;
        logic [8:0] prog [4];
        int         pulses [$];
        int         exp_p [4];
        int         exp_w [5];
        int         idx, k, first;
        logic [8:0] add_w, halt_w;

        rst = 1'b0; in_valid = 1'b0; resume = 1'b0; in_instr = '0;
        rf[0] = 8'h05; rf[1] = 8'h33; rf[2] = 8'hFF; rf[3] = 8'h07;
        add_w  = mk(3'b000, 2'b00, 2'b01, 2'b10);
        halt_w = mk(3'b111, 2'b11, 2'b11, 2'b11);

        // Reset held with valid high: nothing accepted, all outputs zero
        step(1'b0, 1'b1, 1'b0, add_w, acc);
        step(1'b0, 1'b1, 1'b0, add_w, acc);
        chk("rst_acc", 32'(acc), 32'(0));
        chk("rst_retired", 32'(retired), 32'(0));

        // Bring-up program, back-to-back with valid held high
        prog[0] = mk(3'b001, 2'b01, 2'b01, 2'b01);
        prog[1] = mk(3'b010, 2'b00, 2'b10, 2'b10);
        prog[2] = mk(3'b000, 2'b10, 2'b01, 2'b00);
        prog[3] = mk(3'b001, 2'b11, 2'b00, 2'b00);
        idx = 0; k = 0; first = -1;
        while (k < 20 && idx < 4) begin
            step(1'b1, 1'b1, 1'b0, prog[idx], acc);
            if (acc && first < 0) first = k;
            if (first >= 0 && wr) pulses.push_back(k - first + 1);
            if (acc) idx++;
            k++;
        end
        chk("prog_budget", 32'(idx), 32'(4));
        repeat (2) begin
            step(1'b1, 1'b0, 1'b0, '0, acc);
            if (first >= 0 && wr) pulses.push_back(k - first + 1);
            k++;
        end
        exp_p[0] = 1; exp_p[1] = 3; exp_p[2] = 5; exp_p[3] = 7;
        chk("pulse_cnt", 32'(pulses.size()), 32'(4));
        for (int i = 0; i < 4; i++)
            if (i < pulses.size()) chk("pulse_cyc", 32'(pulses[i]), 32'(exp_p[i]));
        chk("rf0", 32'(rf[0]), 32'(8'hFF));
        chk("rf1", 32'(rf[1]), 32'(8'h00));
        chk("rf2", 32'(rf[2]), 32'(8'hFF));
        chk("rf3", 32'(rf[3]), 32'(8'h00));
        chk("prog_retired", 32'(retired), 32'(4));

        // Stall: word offered during WRITE is held until SETTLE
        step(1'b1, 1'b1, 1'b0, add_w, acc);
        chk("stall_first_acc", 32'(acc), 32'(1));
        step(1'b1, 1'b1, 1'b0, mk(3'b001, 2'b11, 2'b10, 2'b01), acc);
        chk("stall_noacc", 32'(acc), 32'(0));
        step(1'b1, 1'b1, 1'b0, mk(3'b001, 2'b11, 2'b10, 2'b01), acc);
        chk("stall_acc", 32'(acc), 32'(1));
        chk("stall_wr", 32'(wr), 32'(1));
        step(1'b1, 1'b0, 1'b0, '0, acc);

        // HALT after one ADD, ignore traffic, resume
        step(1'b0, 1'b0, 1'b0, '0, acc);
        step(1'b1, 1'b1, 1'b0, add_w, acc);
        step(1'b1, 1'b1, 1'b0, halt_w, acc);
        step(1'b1, 1'b1, 1'b0, halt_w, acc);
        chk("halt_acc", 32'(acc), 32'(1));
        chk("halt_flag", 32'(halted), 32'(1));
        chk("halt_retired", 32'(retired), 32'(1));
        repeat (3) begin
            step(1'b1, 1'b1, 1'b0, add_w, acc);
            chk("halt_ignore", 32'(acc), 32'(0));
        end
        step(1'b1, 1'b0, 1'b1, '0, acc);
        chk("resume_flag", 32'(halted), 32'(0));
        step(1'b1, 1'b1, 1'b0, add_w, acc);
        step(1'b1, 1'b0, 1'b0, '0, acc);
        chk("resume_retired", 32'(retired), 32'(2));

        // Reset during WRITE
        step(1'b1, 1'b1, 1'b0, add_w, acc);
        step(1'b0, 1'b0, 1'b0, '0, acc);
        chk("midrst_wr", 32'(wr), 32'(0));
        chk("midrst_retired", 32'(retired), 32'(0));
        step(1'b1, 1'b0, 1'b0, '0, acc);

        // Counter wrap on the 2-bit instance
        exp_w[0] = 1; exp_w[1] = 2; exp_w[2] = 3; exp_w[3] = 0; exp_w[4] = 1;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 1'b0, mk(3'b000, 2'(i), 2'b01, 2'b10), acc);
            step(1'b1, 1'b0, 1'b0, '0, acc);
            chk("wrap", 32'(retired_w), 32'(exp_w[i]));
        end

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 39) != 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 3) == 0), 9'($urandom), acc);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/datapath_sequencer.md
Name: datapath_sequencer

Overview:
- Control-side driver for the 4-register ALU datapath: replaces bench-driven control with an instruction-fed sequencer.
- Accepts packed instruction words over a valid/ready handshake and decodes them into addr1/addr2/addr3/ALUControl/wr for the datapath.
- Runs a per-instruction schedule: one write cycle followed by one settle cycle.
- Supports a HALT opcode and keeps a retired-instruction counter.

Parameters:
- ADDR_W, 2, register address width (4 registers)
- OP_W, 3, ALU control width
- CNT_W, 8, width of the retired-instruction counter
- HALT_OP, 3'b111, opcode treated as HALT and never sent to the ALU

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-low (rst==0 at a rising edge resets)
- in_instr  in  OP_W+3*ADDR_W  instruction, packed {op, addr3, addr1, addr2}; op in MSBs
- in_valid  in  1  in_instr is valid
- in_ready  out  1  sequencer can accept an instruction this cycle
- resume  in  1  leave HALTED state
- addr1  out  ADDR_W  datapath read port A address
- addr2  out  ADDR_W  datapath read port B address
- addr3  out  ADDR_W  datapath write address
- ALUControl  out  OP_W  ALU operation: 000 ADD, 001 SUB, 010 AND; other non-HALT codes passed through unchanged
- wr  out  1  register-file write enable
- halted  out  1  sequencer is in HALTED
- retired  out  CNT_W  count of issued write cycles

Behaviour:
- Reset (rst==0 at edge):
  - state=IDLE; addr1/addr2/addr3/ALUControl=0; wr=0; halted=0; retired=0.
  - Reset overrides everything, including mid-WRITE: wr is 0 the cycle after reset.
  - in_ready is 0 while rst==0.
- States: IDLE, WRITE, SETTLE, HALTED. All outputs are registered except in_ready.
- in_ready = (state==IDLE or state==SETTLE) and rst==1.
- Handshake occurs at an edge where in_valid && in_ready. in_instr is sampled only at a handshake. in_valid without in_ready is ignored, nothing is latched, and the source must hold the word.
- Handshake with op != HALT_OP:
  - addr1/addr2/addr3/ALUControl load from the fields; state goes to WRITE.
  - wr=1 during WRITE, exactly one cycle.
  - Latency: handshake edge N, wr high in cycle N..N+1, regfile captures at edge N+1.
- WRITE -> SETTLE unconditionally. At that edge wr goes to 0 and retired increments, wrapping modulo 2^CNT_W.
- SETTLE: addr/ALUControl hold their values. With no handshake at the SETTLE edge, state goes to IDLE. Back-to-back throughput is one instruction per 2 cycles.
- IDLE: outputs hold their last values, wr=0.
- Handshake with op == HALT_OP:
  - State goes to HALTED; halted=1; wr stays 0.
  - addr/ALUControl are not updated; retired is unchanged.
- HALTED: in_ready=0. resume==1 at an edge -> IDLE and halted=0. in_valid is ignored while halted.
- resume in any state other than HALTED has no effect.
- wr is never high in two consecutive cycles.
- Addresses are never changed while wr is high.

Test Plan:
- Reset: hold rst=0 for 2 cycles with in_valid=1 -> in_ready=0, wr=0, all outputs 0, retired=0. Release rst -> in_ready=1 the next cycle.
- Program from datapath bring-up, issued back-to-back with in_valid held high:
  - {001,01,01,01}, {010,00,10,10}, {000,10,01,00}, {001,11,00,00}
  - Required: wr pulses on cycles 1, 3, 5, 7 after the first handshake; fields match each word during the pulse.
  - Datapath ends with R1=0, R0=-1, R2=-1, R3=0; retired=4.
- Stall: assert in_valid for 1 cycle while in WRITE -> no acceptance, the word is not issued. Hold it until SETTLE -> accepted there, wr next cycle.
- HALT:
  - Send {111,…} after one ADD -> halted=1, in_ready=0, no wr, retired=1.
  - Further in_valid is ignored.
  - resume=1 -> IDLE; the next ADD executes, retired=2.
- Reset mid-operation: drive rst=0 in the WRITE cycle -> wr=0 next cycle, state IDLE, retired=0. The instruction is not counted.
- Counter wrap with CNT_W=2: issue 5 instructions -> retired reads 1,2,3,0,1.
